bw_downscale_2x2: RTL and testbench
===================================

Name: bw_downscale_2x2

Overview:
- Streaming 2x2 box-average downscaler for the 4-bit grayscale pixel stream produced by the RGB-to-BW converter.
- Takes one full-resolution gray frame in raster order and emits a half-width, half-height gray frame for the face-detection stages that follow.
- Keeps a single half-width line buffer of pair sums, so no full frame storage is needed.

Parameters:
IMG_W, 320, input frame width in pixels; must be even and >= 4
IMG_H, 240, input frame height in lines; must be even and >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  in_bw/in_sof valid this cycle; gaps of any length allowed
in_bw  in  4  gray pixel, raster order
in_sof  in  1  marks pixel (0,0) of a frame; qualified by in_valid
out_valid  out  1  one-cycle pulse, output pixel valid
out_bw  out  4  averaged gray pixel
out_sof  out  1  high with out_valid on output pixel (0,0)
out_eol  out  1  high with out_valid on last pixel of each output row (column IMG_W/2-1)
frame_err  out  1  one-cycle pulse on in_sof arriving mid-frame

Behaviour:
Reset and outputs
- Reset (synchronous, rst=1 at a clk edge): state=WAIT_SOF, x=0, y=0, pair-sum register=0.
- All outputs are registered and 0 during and after reset until driven. Line buffer contents are don't-care.
- out_valid, out_sof, out_eol and frame_err are single-cycle pulses; out_bw holds its last value otherwise.
- rst during a frame aborts it: nothing further is output from that frame.

State machine
- WAIT_SOF: accepted pixels (in_valid=1) with in_sof=0 are dropped. in_valid=1 with in_sof=1 processes that pixel as (0,0) and moves to ACTIVE.
- ACTIVE: each accepted pixel advances x (0..IMG_W-1). On x wrap, x=0 and y increments. After pixel (IMG_W-1, IMG_H-1) is accepted, return to WAIT_SOF with x=y=0.
- in_sof=1 in ACTIVE at position (0,0) is a normal frame start, no error.
- in_sof=1 in ACTIVE at any other position:
  - frame_err pulses in the next cycle.
  - The current pixel is processed as (0,0) of a new frame.
  - The partial output of the old frame is abandoned; no out_eol or completion is emitted for it.
- in_valid=0: no state change, no output.

Arithmetic (x even = first pixel of pair, x odd = second)
- x even: pair register <= in_bw.
- y even, x odd: linebuf[x>>1] <= pair + in_bw (5-bit, max 30). No output.
- y odd, x odd: total = linebuf[x>>1] + pair + in_bw (6-bit, max 60).
  - out_bw <= (total + 2) >> 2, i.e. round half up; max (62>>2)=15, so no saturation needed.
  - out_valid=1 in the cycle after this pixel is accepted (latency 1 clk from the accepting edge).
  - out_sof=1 when (x,y)=(1,1).
  - out_eol=1 when x=IMG_W-1.
- Line buffer: IMG_W/2 entries x 5 bits. Every entry is written on the even row before it is read on the odd row, so there is no read-before-write hazard. A simultaneous read and write of the same entry cannot occur.
- Output frame size: IMG_W/2 x IMG_H/2, i.e. exactly IMG_W*IMG_H/4 out_valid pulses per complete frame.
- Maximum throughput: 1 input pixel per clk, with no backpressure.

Test Plan:
1. IMG_W=8, IMG_H=4, every pixel 4'hA, in_valid held high -> 8 outputs all 4'hA; out_sof on output 1 only; out_eol on outputs 4 and 8; frame_err never asserted.
2. Rounding, 2x2 blocks per output:
   - {1,2,3,4} -> 3
   - {F,F,F,F} -> F
   - {0,0,0,1} -> 0
   - {0,0,1,1} -> 1
   - {0,1,1,1} -> 1
   - {1,1,1,1} -> 1
   - {2,2,2,1} -> 2
3. Same frame as test 1 with in_valid toggling 1,0,1,0 and random gaps of up to 5 cycles -> identical out_bw sequence; each out_valid exactly 1 clk after its odd-row, odd-column accept.
4. After reset, 5 pixels with in_valid=1 and in_sof=0, then a normal frame -> the first 5 pixels are ignored; exactly 8 outputs (8x4 frame) with correct values.
5. Start a frame, assert in_sof on the 11th pixel (x=2, y=1) -> frame_err high for exactly one cycle; the new frame then yields 8 correct outputs with out_sof on the first; no output tagged to the old frame after the error.
6. Assert rst for 1 clk mid-odd-row -> next cycle all outputs 0; further in_valid pixels without in_sof are dropped; the following sof frame outputs correctly.

Source files
------------

// File: rtl/bw_downscale_2x2.sv
// rtl/bw_downscale_2x2.sv - streaming 2x2 box-average gray downscaler
// One half-width line buffer holds the even-row pair sums until the odd row completes each block.
module bw_downscale_2x2 #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_bw,
    input  logic       in_sof,
    output logic       out_valid,
    output logic [3:0] out_bw,
    output logic       out_sof,
    output logic       out_eol,
    output logic       frame_err
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LW = XW - 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    pair;
    logic [4:0]    linebuf [IMG_W/2];

    logic          restart;
    logic          accept;
    logic          mid_sof;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [LW-1:0] lb_idx;
    logic [4:0]    lb_rd;
    logic [4:0]    pair_sum;
    logic [5:0]    total;
    logic [5:0]    rounded;

    // A start-of-frame pixel always lands at (0,0), whether or not a frame is in progress.
    always_comb begin
        restart  = in_valid && in_sof;
        accept   = in_valid && (restart || state == ACTIVE);
        mid_sof  = restart && (state == ACTIVE) && ((x != '0) || (y != '0));
        px       = restart ? '0 : x;
        py       = restart ? '0 : y;
        lb_idx   = px[XW-1:1];
        lb_rd    = linebuf[lb_idx];
        pair_sum = {1'b0, pair} + {1'b0, in_bw};
        total    = {1'b0, lb_rd} + {1'b0, pair_sum};
        rounded  = total + 6'd2;
    end

    always_ff @(posedge clk) begin
        if (accept && px[0] && !py[0]) begin
            linebuf[lb_idx] <= pair_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_SOF;
            x         <= '0;
            y         <= '0;
            pair      <= '0;
            out_valid <= 1'b0;
            out_bw    <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            frame_err <= mid_sof;
            if (accept) begin
                if (!px[0]) begin
                    pair <= in_bw;
                end else if (py[0]) begin
                    out_valid <= 1'b1;
                    out_bw    <= rounded[5:2];
                    out_sof   <= (px == X_ONE) && (py == Y_ONE);
                    out_eol   <= (px == X_LAST);
                end
                if (px == X_LAST) begin
                    x <= '0;
                    if (py == Y_LAST) begin
                        y     <= '0;
                        state <= WAIT_SOF;
                    end else begin
                        y     <= py + 1'b1;
                        state <= ACTIVE;
                    end
                end else begin
                    x     <= px + 1'b1;
                    y     <= py;
                    state <= ACTIVE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bw_downscale_2x2.sv
// tb/tb_bw_downscale_2x2.sv - randomized scoreboard bench for bw_downscale_2x2
module tb_bw_downscale_2x2;

    localparam int W = 8;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_bw = '0;
    logic       in_sof = 1'b0;
    logic       out_valid;
    logic [3:0] out_bw;
    logic       out_sof;
    logic       out_eol;
    logic       frame_err;

    bw_downscale_2x2 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bw(in_bw), .in_sof(in_sof),
        .out_valid(out_valid), .out_bw(out_bw), .out_sof(out_sof), .out_eol(out_eol),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] bw;
        logic       sof;
        logic       eol;
        int         cyc;
    } exp_t;

    exp_t expq[$];
    int   errq[$];
    int   checks = 0;
    int   errors = 0;

    int         img [0:H-1][0:W-1];
    bit         in_frame = 0;
    int         idx = 0;
    logic [3:0] fpx [0:W*H-1];

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Reference: remember the accepted frame as an image; each completed 2x2 block yields one rounded average.
    task automatic model_pix(input int p, input bit sof, input int acc);
        int mx, my;
        exp_t e;
        if (sof) begin
            if (in_frame && idx != 0) errq.push_back(acc);
            idx = 0;
            in_frame = 1;
        end else if (!in_frame) begin
            return;
        end
        mx = idx % W;
        my = idx / W;
        img[my][mx] = p;
        if ((mx % 2 == 1) && (my % 2 == 1)) begin
            e.bw  = 4'((img[my-1][mx-1] + img[my-1][mx] + img[my][mx-1] + p + 2) / 4);
            e.sof = (mx == 1 && my == 1);
            e.eol = (mx == W - 1);
            e.cyc = acc;
            expq.push_back(e);
        end
        idx++;
        if (idx == W * H) begin
            in_frame = 0;
            idx = 0;
        end
    endtask

    task automatic drive(input logic [3:0] p, input bit sof, input int gap);
        repeat (gap) begin
            @(posedge clk); #1;
            in_valid = 0;
            in_sof = 0;
        end
        @(posedge clk); #1;
        in_valid = 1;
        in_bw = p;
        in_sof = sof;
        model_pix(p, sof, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 0;
            in_sof = 0;
        end
    endtask

    // gmode: 0 back-to-back, 1 alternating then random gaps, 2 random gaps
    task automatic send_px(input int n, input int gmode);
        int gap;
        for (int i = 0; i < n; i++) begin
            if (gmode == 0 || i == 0) gap = 0;
            else if (gmode == 1 && i < 16) gap = 1;
            else gap = int'($urandom_range(0, 5));
            drive(fpx[i], i == 0, gap);
        end
    endtask

    task automatic fill_const(input logic [3:0] v);
        for (int i = 0; i < W * H; i++) fpx[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < W * H; i++) fpx[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic set_block(input int k, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
        int bi, bj;
        bi = k / (W / 2);
        bj = k % (W / 2);
        fpx[(2*bi)*W + 2*bj]       = a;
        fpx[(2*bi)*W + 2*bj + 1]   = b;
        fpx[(2*bi+1)*W + 2*bj]     = c;
        fpx[(2*bi+1)*W + 2*bj + 1] = d;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_bw"}, int'(out_bw), 0);
        check({tag, "_out_sof"}, int'(out_sof), 0);
        check({tag, "_out_eol"}, int'(out_eol), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        in_valid = 0;
        in_sof = 0;
        rst = 1;
        in_frame = 0;
        idx = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_zero_outputs("post_rst");
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (expq.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("out_bw", int'(out_bw), int'(e.bw));
                check("out_sof", int'(out_sof), int'(e.sof));
                check("out_eol", int'(out_eol), int'(e.eol));
                check("out_latency_cycle", cyc, e.cyc);
            end
        end else begin
            if (out_sof || out_eol) check("tag_without_valid", 1, 0);
        end
        if (frame_err) begin
            if (errq.size() == 0) check("spurious_frame_err", 1, 0);
            else check("frame_err_cycle", cyc, errq.pop_front());
        end
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("in_rst");
        @(posedge clk); #1;
        rst = 0;

        // pixels before any sof are dropped, then a normal frame
        for (int i = 0; i < 5; i++) drive(4'($urandom_range(0, 15)), 1'b0, 0);
        fill_rand();
        send_px(W * H, 0);
        idle(2);

        fill_const(4'hA);
        send_px(W * H, 0);
        idle(2);

        set_block(0, 4'h1, 4'h2, 4'h3, 4'h4);
        set_block(1, 4'hF, 4'hF, 4'hF, 4'hF);
        set_block(2, 4'h0, 4'h0, 4'h0, 4'h1);
        set_block(3, 4'h0, 4'h0, 4'h1, 4'h1);
        set_block(4, 4'h0, 4'h1, 4'h1, 4'h1);
        set_block(5, 4'h1, 4'h1, 4'h1, 4'h1);
        set_block(6, 4'h2, 4'h2, 4'h2, 4'h1);
        set_block(7, 4'h7, 4'h8, 4'h9, 4'h6);
        send_px(W * H, 0);
        idle(3);

        fill_const(4'hA);
        send_px(W * H, 1);
        idle(2);

        // sof on the 11th pixel restarts the frame
        fill_rand();
        send_px(10, 0);
        fill_rand();
        send_px(W * H, 0);
        idle(2);

        // reset mid odd row, then stray pixels, then a full frame
        fill_rand();
        send_px(13, 0);
        pulse_reset();
        for (int i = 0; i < 3; i++) drive(4'($urandom_range(0, 15)), 1'b0, 0);
        fill_rand();
        send_px(W * H, 2);
        idle(2);

        for (int f = 0; f < 3; f++) begin
            fill_rand();
            send_px(W * H, 2);
        end
        idle(2);

        w = 0;
        while ((expq.size() != 0 || errq.size() != 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        check("pending_outputs", expq.size(), 0);
        check("pending_frame_err", errq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
